// File: rtl/laser_req_pkg.sv
// Shared encodings and default timing constants for the windowed laser request detector.
package laser_req_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARM    = 2'd1;
    localparam logic [1:0] ST_ON     = 2'd2;
    localparam logic [1:0] ST_DISARM = 2'd3;

    localparam int DEF_WIN_CYC = 9600000;
    localparam int DEF_OFF_THD = 4800;
    localparam int DEF_WIN_W   = 24;
    localparam int DEF_THD_W   = 16;
    localparam int DEF_CONFIRM = 2;

    // DISARM still reports a request: it is ON waiting for confirmation to drop.
    function automatic logic state_is_req(input logic [1:0] st);
        return (st == ST_ON) || (st == ST_DISARM);
    endfunction

endpackage

// File: rtl/laser_req_chan.sv
// One switch channel: synchroniser, per-window inactive counter, hysteresis FSM and edge pulses.
module laser_req_chan
    import laser_req_pkg::*;
#(
    parameter int OFF_THD = DEF_OFF_THD,
    parameter int THD_W   = DEF_THD_W,
    parameter int CONFIRM = DEF_CONFIRM
) (
    input  logic clk_in,
    input  logic rst_i,
    input  logic sw,
    input  logic en,
    input  logic mode,
    input  logic clr,
    input  logic tick,
    output logic req,
    output logic rise,
    output logic fall
);

    localparam logic [THD_W-1:0] OFF_LIM  = THD_W'(OFF_THD);
    localparam logic [3:0]       CONF_LIM = 4'(CONFIRM);

    logic [1:0]       sync_r;
    logic [THD_W-1:0] off_cnt_r;
    logic [THD_W-1:0] off_inc_s;
    logic [THD_W-1:0] off_nxt_s;
    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [3:0]       conf_r;
    logic [3:0]       conf_nxt_s;
    logic [3:0]       conf_inc_s;
    logic             inactive_s;
    logic             req_nxt_s;

    // Next-state: the tick-cycle sample is folded into the grade; clear/disable override the grade.
    always_comb begin
        off_inc_s   = off_cnt_r;
        conf_inc_s  = conf_r + 4'd1;
        state_nxt_s = state_r;
        conf_nxt_s  = conf_r;
        off_nxt_s   = off_cnt_r;
        if (sync_r[1] && (off_cnt_r != OFF_LIM)) begin
            off_inc_s = off_cnt_r + {{(THD_W-1){1'b0}}, 1'b1};
        end else begin
            off_inc_s = off_cnt_r;
        end
        inactive_s = (off_inc_s >= OFF_LIM);
        if (clr || !en) begin
            state_nxt_s = ST_IDLE;
            conf_nxt_s  = 4'd0;
            off_nxt_s   = {THD_W{1'b0}};
        end else if (tick) begin
            off_nxt_s = {THD_W{1'b0}};
            case (state_r)
                ST_IDLE: begin
                    if (!inactive_s) begin
                        state_nxt_s = (CONF_LIM == 4'd1) ? ST_ON : ST_ARM;
                        conf_nxt_s  = (CONF_LIM == 4'd1) ? 4'd0 : 4'd1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_ARM: begin
                    if (inactive_s) begin
                        state_nxt_s = ST_IDLE;
                        conf_nxt_s  = 4'd0;
                    end else if (conf_inc_s >= CONF_LIM) begin
                        state_nxt_s = ST_ON;
                        conf_nxt_s  = 4'd0;
                    end else begin
                        conf_nxt_s = conf_inc_s;
                    end
                end
                ST_ON: begin
                    if (inactive_s && !mode) begin
                        state_nxt_s = (CONF_LIM == 4'd1) ? ST_IDLE : ST_DISARM;
                        conf_nxt_s  = (CONF_LIM == 4'd1) ? 4'd0 : 4'd1;
                    end else begin
                        state_nxt_s = ST_ON;
                    end
                end
                ST_DISARM: begin
                    if (!inactive_s) begin
                        state_nxt_s = ST_ON;
                        conf_nxt_s  = 4'd0;
                    end else if (conf_inc_s >= CONF_LIM) begin
                        state_nxt_s = ST_IDLE;
                        conf_nxt_s  = 4'd0;
                    end else begin
                        conf_nxt_s = conf_inc_s;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    conf_nxt_s  = 4'd0;
                end
            endcase
        end else begin
            off_nxt_s = off_inc_s;
        end
        req_nxt_s = state_is_req(state_nxt_s);
    end

    // State, counters, synchroniser and registered request/edge outputs.
    always_ff @(posedge clk_in or posedge rst_i) begin
        if (rst_i) begin
            sync_r    <= 2'b00;
            off_cnt_r <= {THD_W{1'b0}};
            state_r   <= ST_IDLE;
            conf_r    <= 4'd0;
            req       <= 1'b0;
            rise      <= 1'b0;
            fall      <= 1'b0;
        end else begin
            sync_r    <= {sync_r[0], sw};
            off_cnt_r <= off_nxt_s;
            state_r   <= state_nxt_s;
            conf_r    <= conf_nxt_s;
            req       <= req_nxt_s;
            rise      <= req_nxt_s & ~req;
            fall      <= ~req_nxt_s & req;
        end
    end

endmodule

// File: rtl/laser_req_window_det.sv
// Multi-channel window-qualified switch request detector; owns the shared window timer.
module laser_req_window_det
    import laser_req_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int WIN_CYC = DEF_WIN_CYC,
    parameter int OFF_THD = DEF_OFF_THD,
    parameter int WIN_W   = DEF_WIN_W,
    parameter int THD_W   = DEF_THD_W,
    parameter int CONFIRM = DEF_CONFIRM
) (
    input  logic           clk_in,
    input  logic           rst_i,
    input  logic [NCH-1:0] sw_in,
    input  logic [NCH-1:0] en_i,
    input  logic [NCH-1:0] mode_i,
    input  logic [NCH-1:0] clr_i,
    output logic [NCH-1:0] req_o,
    output logic [NCH-1:0] rise_o,
    output logic [NCH-1:0] fall_o,
    output logic           win_tick_o
);

    localparam logic [WIN_W-1:0] LAST = WIN_W'(WIN_CYC - 1);

    logic [WIN_W-1:0] timer_r;
    logic [WIN_W-1:0] timer_nxt_s;

    // Timer wrap; the tick register is precomputed so it is high exactly while timer_r == LAST.
    always_comb begin
        if (timer_r == LAST) begin
            timer_nxt_s = {WIN_W{1'b0}};
        end else begin
            timer_nxt_s = timer_r + {{(WIN_W-1){1'b0}}, 1'b1};
        end
    end

    // Shared window timer and tick; never affected by per-channel clear/enable.
    always_ff @(posedge clk_in or posedge rst_i) begin
        if (rst_i) begin
            timer_r    <= {WIN_W{1'b0}};
            win_tick_o <= 1'b0;
        end else begin
            timer_r    <= timer_nxt_s;
            win_tick_o <= (timer_nxt_s == LAST);
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        laser_req_chan #(
            .OFF_THD (OFF_THD),
            .THD_W   (THD_W),
            .CONFIRM (CONFIRM)
        ) u_chan (
            .clk_in (clk_in),
            .rst_i  (rst_i),
            .sw     (sw_in[g]),
            .en     (en_i[g]),
            .mode   (mode_i[g]),
            .clr    (clr_i[g]),
            .tick   (win_tick_o),
            .req    (req_o[g]),
            .rise   (rise_o[g]),
            .fall   (fall_o[g])
        );
    end

endmodule

// File: tb/tb_laser_req_window_det.sv
// Directed self-checking bench: NCH=2, 16-cycle windows, threshold 4, confirm 2.
module tb_laser_req_window_det;

    logic       clk_in = 1'b0;
    logic       rst_i;
    logic [1:0] sw_in;
    logic [1:0] en_i;
    logic [1:0] mode_i;
    logic [1:0] clr_i;
    logic [1:0] req_o;
    logic [1:0] rise_o;
    logic [1:0] fall_o;
    logic       win_tick_o;

    int checks = 0;
    int errors = 0;

    laser_req_window_det #(
        .NCH(2), .WIN_CYC(16), .OFF_THD(4), .WIN_W(5), .THD_W(3), .CONFIRM(2)
    ) dut (
        .clk_in     (clk_in),
        .rst_i      (rst_i),
        .sw_in      (sw_in),
        .en_i       (en_i),
        .mode_i     (mode_i),
        .clr_i      (clr_i),
        .req_o      (req_o),
        .rise_o     (rise_o),
        .fall_o     (fall_o),
        .win_tick_o (win_tick_o)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic wait_tick();
        int k;
        k = 0;
        while (win_tick_o !== 1'b1 && k < 40) begin
            @(negedge clk_in);
            k++;
        end
        check("tick_seen", {7'd0, win_tick_o}, 8'd1);
    endtask

    // Returns at the negedge after the deciding clock edge of the next window.
    task automatic next_decision();
        wait_tick();
        step(1);
    endtask

    task automatic pulse_sw(input logic [1:0] mask, input int n);
        sw_in = sw_in | mask;
        step(n);
        sw_in = sw_in & ~mask;
    endtask

    initial begin
        rst_i  = 1'b1;
        sw_in  = 2'b00;
        en_i   = 2'b11;
        mode_i = 2'b00;
        clr_i  = 2'b00;

        // 1: reset state, then two active windows arm and turn on
        step(3);
        check("rst_req",  {6'd0, req_o},  8'h00);
        check("rst_rise", {6'd0, rise_o}, 8'h00);
        check("rst_fall", {6'd0, fall_o}, 8'h00);
        check("rst_tick", {7'd0, win_tick_o}, 8'h00);
        rst_i = 1'b0;
        step(14);
        check("tick_c14", {7'd0, win_tick_o}, 8'h00);
        step(1);
        check("tick_c15", {7'd0, win_tick_o}, 8'h01);
        step(1);
        check("arm_req",  {6'd0, req_o}, 8'h00);
        check("arm_rise", {6'd0, rise_o}, 8'h00);
        next_decision();
        check("on_req",  {6'd0, req_o},  8'h03);
        check("on_rise", {6'd0, rise_o}, 8'h03);
        step(1);
        check("on_rise_end", {6'd0, rise_o}, 8'h00);
        check("on_req_hold", {6'd0, req_o},  8'h03);

        // 2: 3 highs stay ON; two windows of 4 highs fall
        pulse_sw(2'b01, 3);
        next_decision();
        check("thd3_req",  {6'd0, req_o},  8'h03);
        check("thd3_fall", {6'd0, fall_o}, 8'h00);
        pulse_sw(2'b01, 4);
        next_decision();
        check("disarm_req",  {6'd0, req_o},  8'h03);
        check("disarm_fall", {6'd0, fall_o}, 8'h00);
        pulse_sw(2'b01, 4);
        next_decision();
        check("off_req",  {6'd0, req_o},  8'h02);
        check("off_fall", {6'd0, fall_o}, 8'h01);

        // 3: ch1 one inactive window then active stays on; ch0 re-arms
        pulse_sw(2'b10, 5);
        next_decision();
        check("hyst_req",  {6'd0, req_o},  8'h02);
        check("hyst_rise", {6'd0, rise_o}, 8'h00);
        check("hyst_fall", {6'd0, fall_o}, 8'h00);
        next_decision();
        check("hyst2_req",  {6'd0, req_o},  8'h03);
        check("hyst2_rise", {6'd0, rise_o}, 8'h01);
        check("hyst2_fall", {6'd0, fall_o}, 8'h00);

        // 4: latch mode ignores inactive windows until clear
        mode_i = 2'b01;
        sw_in  = 2'b01;
        for (int w = 0; w < 5; w++) begin
            next_decision();
            check("latch_req",  {6'd0, req_o},  8'h03);
            check("latch_fall", {6'd0, fall_o}, 8'h00);
        end
        clr_i = 2'b01;
        sw_in = 2'b00;
        step(1);
        clr_i  = 2'b00;
        mode_i = 2'b00;
        check("clr_req",  {6'd0, req_o},  8'h02);
        check("clr_fall", {6'd0, fall_o}, 8'h01);
        step(1);
        check("clr_fall_end", {6'd0, fall_o}, 8'h00);

        // 5: clear on the deciding tick wins over the grade
        next_decision();
        check("rearm_req", {6'd0, req_o}, 8'h02);
        wait_tick();
        clr_i = 2'b01;
        step(1);
        clr_i = 2'b00;
        check("clrtick_req",  {6'd0, req_o},  8'h02);
        check("clrtick_rise", {6'd0, rise_o}, 8'h00);
        next_decision();
        check("idle_arm_req", {6'd0, req_o}, 8'h02);
        next_decision();
        check("reon_req",  {6'd0, req_o},  8'h03);
        check("reon_rise", {6'd0, rise_o}, 8'h01);

        // 5b: disable ch0 while ON
        en_i = 2'b10;
        step(1);
        check("dis_req",  {6'd0, req_o},  8'h02);
        check("dis_fall", {6'd0, fall_o}, 8'h01);
        step(1);
        check("dis_fall_end", {6'd0, fall_o}, 8'h00);
        next_decision();
        check("dis_hold_req", {6'd0, req_o}, 8'h02);
        en_i = 2'b11;

        // 6: reset mid-window
        step(5);
        rst_i = 1'b1;
        #1;
        check("mrst_req",  {6'd0, req_o}, 8'h00);
        check("mrst_tick", {7'd0, win_tick_o}, 8'h00);
        step(2);
        check("mrst_rise", {6'd0, rise_o}, 8'h00);
        check("mrst_fall", {6'd0, fall_o}, 8'h00);
        rst_i = 1'b0;
        step(14);
        check("mrst_tick_c14", {7'd0, win_tick_o}, 8'h00);
        step(1);
        check("mrst_tick_c15", {7'd0, win_tick_o}, 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
